// File: rtl/gate_sweep_checker_if.sv
// Bus between a gate_sweep_checker and its environment: the sweep
// request/result signals plus the gate-under-test drive and sense lines.
interface gate_sweep_checker_if #(
    parameter int N_IN = 2
);
    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [2**N_IN-1:0]   tt;
    logic [N_IN:0]        err_count;
    logic                 fail_valid;
    logic [N_IN-1:0]      fail_idx;
    logic [N_IN-1:0]      dut_in;
    logic                 dut_out;

    // Checker side: takes the request and the GUT output, drives everything else.
    modport slave (
        input  start, dut_out,
        output busy, done, pass, tt, err_count, fail_valid, fail_idx, dut_in
    );

    // Environment side: requests sweeps, feeds back the GUT output, reads results.
    modport master (
        output start, dut_out,
        input  busy, done, pass, tt, err_count, fail_valid, fail_idx, dut_in
    );
endinterface

// File: rtl/gate_sweep_checker.sv
// Sequential truth-table exerciser: applies every input vector to a small
// combinational gate, holds it SETTLE+1 cycles, samples the gate output,
// and compares the observed table against EXP_TT.
module gate_sweep_checker #(
    parameter int                 N_IN   = 2,
    parameter int                 SETTLE = 1,
    parameter logic [2**N_IN-1:0] EXP_TT = 4'b0110
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_sweep_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};
    localparam logic [3:0]      SETTLE_L = 4'(SETTLE);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_sample;
    logic                 w_last;
    logic                 w_count;
    logic                 w_mismatch;

    logic [N_IN-1:0]      r_idx;
    logic [3:0]           r_settle;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_pass;
    logic [2**N_IN-1:0]   r_tt;
    logic [N_IN:0]        r_err_count;
    logic                 r_fail_valid;
    logic [N_IN-1:0]      r_fail_idx;
    logic [N_IN-1:0]      r_dut_in;

    // Sampled gate output disagrees with the expected table entry for this vector.
    function automatic logic f_mismatch(input logic sampled, input logic [N_IN-1:0] idx);
        return sampled != EXP_TT[idx];
    endfunction

    assign w_mismatch = f_mismatch(bus.dut_out, r_idx);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and per-cycle strobes (accept, sample, last vector, settle count).
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        w_last      = 1'b0;
        w_count     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (r_settle == 4'd0) begin
                    w_sample = 1'b1;
                    if (r_idx == LAST_IDX) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_HOLD;
                    end
                end else begin
                    w_count     = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Sweep datapath: vector drive, settle timer, observed table and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_settle     <= 4'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_tt         <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
            r_dut_in     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_busy       <= 1'b1;
                r_dut_in     <= '0;
                r_idx        <= '0;
                r_settle     <= SETTLE_L;
                r_tt         <= '0;
                r_err_count  <= '0;
                r_fail_valid <= 1'b0;
                r_fail_idx   <= '0;
                r_pass       <= 1'b0;
            end else if (w_sample) begin
                r_tt[r_idx] <= bus.dut_out;
                if (w_mismatch) begin
                    r_err_count <= r_err_count + (N_IN+1)'(1);
                    if (!r_fail_valid) begin
                        r_fail_idx   <= r_idx;
                        r_fail_valid <= 1'b1;
                    end
                end
                if (w_last) begin
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_dut_in <= '0;
                    r_idx    <= '0;
                    r_pass   <= (r_err_count == '0) && !w_mismatch;
                end else begin
                    r_idx    <= r_idx + N_IN'(1);
                    r_dut_in <= r_idx + N_IN'(1);
                    r_settle <= SETTLE_L;
                end
            end else if (w_count) begin
                r_settle <= r_settle - 4'd1;
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.tt         = r_tt;
    assign bus.err_count  = r_err_count;
    assign bus.fail_valid = r_fail_valid;
    assign bus.fail_idx   = r_fail_idx;
    assign bus.dut_in     = r_dut_in;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Scoreboard bench for gate_sweep_checker: a 2-input instance (SETTLE=1,
// XOR expected) and a 3-input instance (SETTLE=0, parity expected).
module tb_gate_sweep_checker;

    logic clk;
    logic rst_n;
    logic gut_and;
    logic gut3_zero;
    int   cyc;
    int   n_chk;
    int   n_err;

    typedef struct {
        int         cyc;
        logic [7:0] tt;
        logic [3:0] err;
        logic       fv;
        logic [2:0] fi;
        logic       pass;
    } exp_t;

    exp_t q2[$];
    exp_t q3[$];

    gate_sweep_checker_if #(.N_IN(2)) bus2 ();
    gate_sweep_checker_if #(.N_IN(3)) bus3 ();

    gate_sweep_checker #(.N_IN(2), .SETTLE(1), .EXP_TT(4'b0110)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    gate_sweep_checker #(.N_IN(3), .SETTLE(0), .EXP_TT(8'h96)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    // Gates under test.
    assign bus2.dut_out = gut_and ? (bus2.dut_in[1] & bus2.dut_in[0])
                                  : (bus2.dut_in[1] ^ bus2.dut_in[0]);
    assign bus3.dut_out = gut3_zero ? 1'b0 : (^bus3.dut_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input int c, input logic [7:0] t, input logic [3:0] e,
                                input logic fv, input logic [2:0] fi, input logic p);
        exp_t r;
        r.cyc = c; r.tt = t; r.err = e; r.fv = fv; r.fi = fi; r.pass = p;
        return r;
    endfunction

    // Scoreboard: each done pulse pops one expectation and compares everything.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus2.done) begin
                if (q2.size() == 0) begin
                    chk("dut2_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q2.pop_front();
                    chk("dut2_done_cycle", cyc, e.cyc);
                    chk("dut2_tt", {28'd0, bus2.tt}, {24'd0, e.tt});
                    chk("dut2_err_count", {29'd0, bus2.err_count}, {28'd0, e.err});
                    chk("dut2_fail_valid", {31'd0, bus2.fail_valid}, {31'd0, e.fv});
                    chk("dut2_fail_idx", {30'd0, bus2.fail_idx}, {29'd0, e.fi});
                    chk("dut2_pass", {31'd0, bus2.pass}, {31'd0, e.pass});
                    chk("dut2_busy_at_done", {31'd0, bus2.busy}, 32'd0);
                end
            end
            if (bus3.done) begin
                if (q3.size() == 0) begin
                    chk("dut3_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q3.pop_front();
                    chk("dut3_done_cycle", cyc, e.cyc);
                    chk("dut3_tt", {24'd0, bus3.tt}, {24'd0, e.tt});
                    chk("dut3_err_count", {28'd0, bus3.err_count}, {28'd0, e.err});
                    chk("dut3_fail_valid", {31'd0, bus3.fail_valid}, {31'd0, e.fv});
                    chk("dut3_fail_idx", {29'd0, bus3.fail_idx}, {29'd0, e.fi});
                    chk("dut3_pass", {31'd0, bus3.pass}, {31'd0, e.pass});
                    chk("dut3_busy_at_done", {31'd0, bus3.busy}, 32'd0);
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_empty(input int budget);
        int k = 0;
        while ((q2.size() != 0 || q3.size() != 0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("sweep_timeout", q2.size() + q3.size(), 32'd0);
        q2.delete();
        q3.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero2(input string tag);
        chk({tag, "_busy"}, {31'd0, bus2.busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, bus2.done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, bus2.pass}, 32'd0);
        chk({tag, "_tt"}, {28'd0, bus2.tt}, 32'd0);
        chk({tag, "_err"}, {29'd0, bus2.err_count}, 32'd0);
        chk({tag, "_fv"}, {31'd0, bus2.fail_valid}, 32'd0);
        chk({tag, "_fi"}, {30'd0, bus2.fail_idx}, 32'd0);
        chk({tag, "_dut_in"}, {30'd0, bus2.dut_in}, 32'd0);
    endtask

    initial begin
        int e0;
        n_chk = 0; n_err = 0; cyc = 0;
        rst_n = 1'b0; gut_and = 1'b0; gut3_zero = 1'b0;
        bus2.start = 1'b0; bus3.start = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero2("reset");
        chk("reset_dut3_busy", {31'd0, bus3.busy}, 32'd0);
        chk("reset_dut3_tt", {24'd0, bus3.tt}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: XOR gate, single start pulse, dut_in steps every two cycles.
        gut_and = 1'b0;
        bus2.start = 1'b1;
        e0 = cyc + 1;
        q2.push_back(mk(e0 + 8, 8'h06, 4'd0, 1'b0, 3'd0, 1'b1));
        for (int j = 0; j <= 8; j++) begin
            @(negedge clk);
            bus2.start = 1'b0;
            chk("xor_dut_in_step", {30'd0, bus2.dut_in}, (j < 8) ? (j / 2) : 0);
            chk("xor_busy", {31'd0, bus2.busy}, (j < 8) ? 32'd1 : 32'd0);
        end
        wait_empty(40);

        // 2: AND gate.
        gut_and = 1'b1;
        bus2.start = 1'b1;
        e0 = cyc + 1;
        q2.push_back(mk(e0 + 8, 8'h08, 4'd3, 1'b1, 3'd1, 1'b0));
        @(negedge clk);
        bus2.start = 1'b0;
        wait_empty(40);

        // 3: start held high: re-accepted in each DONE cycle, results cleared.
        gut_and = 1'b1;
        bus2.start = 1'b1;
        e0 = cyc + 1;
        q2.push_back(mk(e0 + 8,  8'h08, 4'd3, 1'b1, 3'd1, 1'b0));
        q2.push_back(mk(e0 + 17, 8'h08, 4'd3, 1'b1, 3'd1, 1'b0));
        q2.push_back(mk(e0 + 26, 8'h08, 4'd3, 1'b1, 3'd1, 1'b0));
        while (cyc < e0 + 20) begin
            @(negedge clk);
            if (cyc == e0 + 9 || cyc == e0 + 18) begin
                chk("restart_busy", {31'd0, bus2.busy}, 32'd1);
                chk("restart_err_clear", {29'd0, bus2.err_count}, 32'd0);
                chk("restart_fv_clear", {31'd0, bus2.fail_valid}, 32'd0);
            end
        end
        bus2.start = 1'b0;
        wait_empty(60);

        // 4: asynchronous reset after vector 2 is applied; then a clean sweep.
        gut_and = 1'b0;
        bus2.start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        bus2.start = 1'b0;
        wait_cyc(e0 + 4);
        chk("pre_reset_dut_in", {30'd0, bus2.dut_in}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero2("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_reset_idle_busy", {31'd0, bus2.busy}, 32'd0);
        bus2.start = 1'b1;
        e0 = cyc + 1;
        q2.push_back(mk(e0 + 8, 8'h06, 4'd0, 1'b0, 3'd0, 1'b1));
        @(negedge clk);
        bus2.start = 1'b0;
        wait_empty(40);

        // 5: 3-input parity instance, SETTLE=0; then GUT stuck at 0.
        gut3_zero = 1'b0;
        bus3.start = 1'b1;
        e0 = cyc + 1;
        q3.push_back(mk(e0 + 8, 8'h96, 4'd0, 1'b0, 3'd0, 1'b1));
        @(negedge clk);
        bus3.start = 1'b0;
        wait_empty(40);
        gut3_zero = 1'b1;
        bus3.start = 1'b1;
        e0 = cyc + 1;
        q3.push_back(mk(e0 + 8, 8'h00, 4'd4, 1'b1, 3'd1, 1'b0));
        @(negedge clk);
        bus3.start = 1'b0;
        wait_empty(40);

        // 6: extra start pulses while busy are ignored.
        gut_and = 1'b0;
        bus2.start = 1'b1;
        e0 = cyc + 1;
        q2.push_back(mk(e0 + 8, 8'h06, 4'd0, 1'b0, 3'd0, 1'b1));
        @(negedge clk);
        bus2.start = 1'b0;
        wait_cyc(e0 + 2);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        wait_cyc(e0 + 4);
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        wait_empty(40);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
